// File: rtl/led_serializer.sv
// MSB-first serializer for a 74HC595-style LED chain: shift clock from a CLK_DIV divider, then a latch pulse.
// Optional macro LED_SER_AUTO_REFRESH_EN re-sends the shadow word after REFRESH_CYCLES idle cycles.
module led_serializer #(
  parameter int WIDTH          = 16,
  parameter int CLK_DIV        = 4,
  parameter int REFRESH_CYCLES = 65536
) (
  input  logic             i_CLK,
  input  logic             i_RESET,
  input  logic [WIDTH-1:0] i_Data,
  input  logic             i_Valid,
  output logic             o_Ready,
  output logic             o_SER_Data,
  output logic             o_SER_CLK,
  output logic             o_SER_Latch,
  output logic             o_Busy,
  output logic             o_Done
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RISE, S_LATCH} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             ser_data_q, ser_data_d;
  logic             ser_clk_q, ser_clk_d;
  logic             latch_q, latch_d;
  logic             done_q, done_d;
  logic             div_end;
  logic             accept;
  logic             refresh_start;

  if (WIDTH < 2 || CLK_DIV < 1 || REFRESH_CYCLES < 2) begin : g_param_check
    $error("led_serializer: illegal parameter combination");
  end

  assign div_end = (div_q == DIV_W'(CLK_DIV - 1));

`ifdef LED_SER_AUTO_REFRESH_EN
  localparam int CNT_W = $clog2(REFRESH_CYCLES + 1);
  logic [CNT_W-1:0] idle_q;

  // A real request in the same cycle takes priority over the refresh.
  assign refresh_start = (state_q == S_IDLE) && !i_RESET && !i_Valid &&
                         (idle_q == CNT_W'(REFRESH_CYCLES - 1));

  always_ff @(posedge i_CLK) begin
    if (i_RESET || (state_q == S_IDLE && state_d != S_IDLE)) begin
      idle_q <= '0;
    end else if (state_q == S_IDLE) begin
      idle_q <= idle_q + CNT_W'(1);
    end
  end
`else
  assign refresh_start = 1'b0;
`endif

  assign o_Ready = (state_q == S_IDLE) && !i_RESET && !refresh_start;
  assign accept  = i_Valid && o_Ready;
  assign o_Busy  = (state_q != S_IDLE);

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state_q    <= S_IDLE;
      shadow_q   <= '0;
      idx_q      <= '0;
      div_q      <= '0;
      ser_data_q <= 1'b0;
      ser_clk_q  <= 1'b0;
      latch_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      idx_q      <= idx_d;
      div_q      <= div_d;
      ser_data_q <= ser_data_d;
      ser_clk_q  <= ser_clk_d;
      latch_q    <= latch_d;
      done_q     <= done_d;
    end
  end

  // Divider wraps exactly when a timed state ends, so it clears on every state change.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    div_d    = div_end ? '0 : div_q + DIV_W'(1);
    case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (accept) begin
          shadow_d = i_Data;
          idx_d    = IDX_W'(WIDTH - 1);
          state_d  = S_SETUP;
        end else if (refresh_start) begin
          idx_d    = IDX_W'(WIDTH - 1);
          state_d  = S_SETUP;
        end
      end
      S_SETUP: if (div_end) state_d = S_RISE;
      S_RISE: begin
        if (div_end) begin
          if (idx_q == '0) begin
            state_d = S_LATCH;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = S_SETUP;
          end
        end
      end
      S_LATCH: if (div_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pin values are registered from the next state so they line up with the state register.
  always_comb begin
    ser_clk_d  = (state_d == S_RISE);
    latch_d    = (state_d == S_LATCH);
    ser_data_d = 1'b0;
    if (state_d == S_SETUP) begin
      ser_data_d = shadow_d[idx_d];
    end else if (state_d == S_RISE) begin
      ser_data_d = ser_data_q;
    end
    done_d = (state_q == S_LATCH) && (state_d == S_IDLE);
  end

  assign o_SER_Data  = ser_data_q;
  assign o_SER_CLK   = ser_clk_q;
  assign o_SER_Latch = latch_q;
  assign o_Done      = done_q;
endmodule
